// File: rtl/johnson_monitor.sv
// Johnson counter monitor: tracks a 4-bit Johnson sequence, locks after LOCK_LEN legal steps, counts revolutions.
// Optional stall detection while LOCKED is compiled in with macro JOHNSON_STALL_CHECK_EN.
module johnson_monitor #(
    parameter int unsigned LOCK_LEN = 4
`ifdef JOHNSON_STALL_CHECK_EN
    ,
    parameter int unsigned STALL_LIM = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       count_vld,
    input  logic       err_clr,
    output logic [7:0] phase,
    output logic [7:0] rev_cnt,
    output logic       locked,
    output logic       seq_err,
    output logic       illegal_err
`ifdef JOHNSON_STALL_CHECK_EN
    ,
    output logic       stall_err
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_W = 4'(LOCK_LEN);

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  phase_q, phase_d;
    logic [7:0]  rev_q, rev_d;
    logic        seq_err_q, seq_err_d;
    logic        ill_err_q, ill_err_d;

    logic        legal;
    logic [2:0]  idx;
    logic [3:0]  succ;
    logic        is_step;
    logic        seq_ev, ill_ev;

`ifdef JOHNSON_STALL_CHECK_EN
    localparam logic [7:0] STALL_W = 8'(STALL_LIM);
    logic [7:0]  idle_q, idle_d;
    logic        stall_err_q, stall_err_d;
    logic        stall_ev;
`endif

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (count_in)
            4'b0000: idx = 3'd0;
            4'b0001: idx = 3'd1;
            4'b0011: idx = 3'd2;
            4'b0111: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b1110: idx = 3'd5;
            4'b1100: idx = 3'd6;
            4'b1000: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    // last_q only ever holds a legal code, so its shift successor is always legal too
    assign succ    = {last_q[2:0], ~last_q[3]};
    assign is_step = legal && (count_in == succ);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        last_d   = last_q;
        phase_d  = phase_q;
        rev_d    = rev_q;
        seq_ev   = 1'b0;
        ill_ev   = 1'b0;
`ifdef JOHNSON_STALL_CHECK_EN
        idle_d   = idle_q;
        stall_ev = 1'b0;
`endif
        if (count_vld) begin
            if (state_q == SEARCH) begin
                if (legal) begin
                    last_d   = count_in;
                    phase_d  = 8'b1 << idx;
                    streak_d = '0;
                    state_d  = TRACK;
                end else begin
                    ill_ev = 1'b1;
                end
            end else if (!legal) begin
                ill_ev   = 1'b1;
                phase_d  = '0;
                streak_d = '0;
                state_d  = SEARCH;
            end else if (is_step) begin
                last_d   = count_in;
                phase_d  = 8'b1 << idx;
                streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                if (last_q == 4'b1000) rev_d = rev_q + 8'd1;
                if (state_q == TRACK && streak_d >= LOCK_W) state_d = LOCKED;
            end else begin
                seq_ev   = 1'b1;
                last_d   = count_in;
                phase_d  = 8'b1 << idx;
                streak_d = '0;
                state_d  = TRACK;
            end
        end
`ifdef JOHNSON_STALL_CHECK_EN
        if (count_vld) begin
            idle_d = '0;
        end else if (state_q == LOCKED) begin
            if (idle_q + 8'd1 == STALL_W) begin
                stall_ev = 1'b1;
                idle_d   = '0;
                streak_d = '0;
                state_d  = SEARCH;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end
        stall_err_d = (stall_err_q & ~err_clr) | stall_ev;
`endif
        seq_err_d = (seq_err_q & ~err_clr) | seq_ev;
        ill_err_d = (ill_err_q & ~err_clr) | ill_ev;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            streak_q    <= '0;
            last_q      <= '0;
            phase_q     <= '0;
            rev_q       <= '0;
            seq_err_q   <= 1'b0;
            ill_err_q   <= 1'b0;
`ifdef JOHNSON_STALL_CHECK_EN
            idle_q      <= '0;
            stall_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            last_q      <= last_d;
            phase_q     <= phase_d;
            rev_q       <= rev_d;
            seq_err_q   <= seq_err_d;
            ill_err_q   <= ill_err_d;
`ifdef JOHNSON_STALL_CHECK_EN
            idle_q      <= idle_d;
            stall_err_q <= stall_err_d;
`endif
        end
    end

    assign phase       = phase_q;
    assign rev_cnt     = rev_q;
    assign locked      = (state_q == LOCKED);
    assign seq_err     = seq_err_q;
    assign illegal_err = ill_err_q;
`ifdef JOHNSON_STALL_CHECK_EN
    assign stall_err   = stall_err_q;
`endif

endmodule
